// File: rtl/iiitb_mem_arbiter.sv
// Two-master arbiter (instruction fetch and data) in front of a single-port word memory.
// Data has priority. A bounded data streak forces a fetch through so the fetch cannot starve.
module iiitb_mem_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MAX_D_BURST = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned SW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0] MaxStreak = SW'(MAX_D_BURST);

  typedef enum logic [1:0] {StIdle, StRdIf, StRdD} state_e;

  state_e        state_q;
  logic [SW-1:0] d_streak_q;
  logic [31:0]   if_rdata_q, d_rdata_q;

  logic in_idle, streak_max, if_win, d_win;

  // Reset gates the combinational grant path so nothing leaks out while held in reset.
  assign in_idle    = reset && (state_q == StIdle);
  assign streak_max = (d_streak_q == MaxStreak);
  assign if_win     = in_idle && if_req && (!d_req || streak_max);
  assign d_win      = in_idle && d_req && !if_win;

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign mem_en    = if_win || d_win;
  assign mem_we    = d_win && d_we;
  assign mem_wdata = (d_win && d_we) ? d_wdata : '0;

  always_comb begin
    mem_addr = '0;
    if (if_win) begin
      mem_addr = if_addr[ADDR_W+1:2];
    end else if (d_win) begin
      mem_addr = d_addr[ADDR_W+1:2];
    end
  end

  assign if_valid = reset && (state_q == StRdIf);
  assign d_valid  = reset && (state_q == StRdD);
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign d_rdata  = d_valid ? mem_rdata : d_rdata_q;

  // Byte-offset and above-range address bits are intentionally discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      d_streak_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!if_req || if_win) begin
            d_streak_q <= '0;
          end else if (d_win && !streak_max) begin
            d_streak_q <= d_streak_q + 1'b1;
          end
          if (if_win) begin
            state_q <= StRdIf;
          end else if (d_win && !d_we) begin
            state_q <= StRdD;
          end else begin
            state_q <= StIdle;
          end
        end
        StRdIf: begin
          if_rdata_q <= mem_rdata;
          state_q    <= StIdle;
        end
        StRdD: begin
          d_rdata_q <= mem_rdata;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_mem_arbiter.sv
// Directed bench for iiitb_mem_arbiter: a transaction-level model is checked every cycle,
// and literal expectations pin the key scenarios.
module tb_iiitb_mem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned MAXB   = 2;
  localparam int unsigned WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, d_req, d_we;
  logic [31:0]       if_addr, d_addr, d_wdata;
  logic              if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we;
  logic [31:0]       if_rdata, d_rdata, mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;

  int n_vec = 0;
  int n_err = 0;
  bit run   = 1'b0;

  iiitb_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT: one-cycle read latency.
  logic [31:0] ram [WORDS];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: pending read kind, its data, streak count and expected memory image.
  int          m_pend = 0;  // 0 none, 1 fetch read, 2 data read
  int          m_streak = 0;
  logic [31:0] m_pend_data = '0, m_if_last = '0, m_d_last = '0;
  logic [31:0] m_mem [WORDS];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  always @(negedge clk) begin
    if (run) begin
      if (!reset) begin
        chk("rst if_gnt", if_gnt, 0);     chk("rst d_gnt", d_gnt, 0);
        chk("rst mem_en", mem_en, 0);     chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0); chk("rst mem_wdata", mem_wdata, 0);
        chk("rst if_valid", if_valid, 0); chk("rst d_valid", d_valid, 0);
        chk("rst if_rdata", if_rdata, 0); chk("rst d_rdata", d_rdata, 0);
        m_pend = 0; m_streak = 0; m_if_last = '0; m_d_last = '0;
      end else if (m_pend != 0) begin
        chk("busy if_gnt", if_gnt, 0); chk("busy d_gnt", d_gnt, 0);
        chk("busy mem_en", mem_en, 0); chk("busy mem_we", mem_we, 0);
        chk("if_valid", if_valid, m_pend == 1);
        chk("d_valid", d_valid, m_pend == 2);
        if (m_pend == 1) m_if_last = m_pend_data;
        else m_d_last = m_pend_data;
        chk("if_rdata", if_rdata, m_if_last);
        chk("d_rdata", d_rdata, m_d_last);
        m_pend = 0;
      end else begin
        bit fw, dw;
        fw = if_req && (!d_req || m_streak >= MAXB);
        dw = d_req && !fw;
        chk("if_gnt", if_gnt, fw);
        chk("d_gnt", d_gnt, dw);
        chk("mem_en", mem_en, fw || dw);
        chk("mem_we", mem_we, dw && d_we);
        chk("idle if_valid", if_valid, 0); chk("idle d_valid", d_valid, 0);
        chk("hold if_rdata", if_rdata, m_if_last);
        chk("hold d_rdata", d_rdata, m_d_last);
        if (fw) begin
          chk("if mem_addr", mem_addr, widx(if_addr));
          m_pend = 1; m_pend_data = m_mem[widx(if_addr)];
        end else if (dw) begin
          chk("d mem_addr", mem_addr, widx(d_addr));
          if (d_we) begin
            chk("mem_wdata", mem_wdata, d_wdata);
            m_mem[widx(d_addr)] = d_wdata;
          end else begin
            m_pend = 2; m_pend_data = m_mem[widx(d_addr)];
          end
        end
        if (!if_req || fw) m_streak = 0;
        else if (dw && m_streak < MAXB) m_streak++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] seq;
    int ng;
    for (int i = 0; i < int'(WORDS); i++) begin
      ram[i] = 32'(i);
      m_mem[i] = 32'(i);
    end
    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    #1 reset = 1'b0;
    if_req = 1; d_req = 1; d_we = 1;
    run = 1'b1;
    @(negedge clk);
    chk("reset gates if_gnt", if_gnt, 0);
    chk("reset gates mem_en", mem_en, 0);
    tick(); reset = 1'b1; d_req = 0; d_we = 0;

    // Fetch only, granted in the first cycle after reset release
    if_addr = 32'h8;
    @(negedge clk);
    chk("L fetch gnt", if_gnt, 1); chk("L fetch mem_en", mem_en, 1);
    chk("L fetch addr", mem_addr, 2);
    tick(); if_req = 0;
    @(negedge clk);
    chk("L fetch valid", if_valid, 1); chk("L fetch data", if_rdata, 32'h2);
    tick();

    // Data write then read back
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("L wr gnt", d_gnt, 1); chk("L wr we", mem_we, 1); chk("L wr addr", mem_addr, 2);
    tick(); d_we = 0;
    @(negedge clk);
    chk("L wr no valid", d_valid, 0); chk("L rd gnt", d_gnt, 1);
    tick(); d_req = 0;
    @(negedge clk);
    chk("L rd valid", d_valid, 1); chk("L rd data", d_rdata, 32'hDEADBEEF);
    tick();

    // Simultaneous single requests
    if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h14;
    @(negedge clk);
    chk("L sim d first", d_gnt, 1); chk("L sim if wait", if_gnt, 0);
    tick(); d_req = 0;
    @(negedge clk);
    chk("L sim d data", d_rdata, 32'h5);
    tick();
    @(negedge clk);
    chk("L sim if gnt", if_gnt, 1); chk("L sim if addr", mem_addr, 4);
    tick(); if_req = 0;
    @(negedge clk);
    chk("L sim if valid", if_valid, 1); chk("L sim if data", if_rdata, 32'h4);
    tick();

    // Continuous contention
    if_req = 1; d_req = 1; if_addr = 32'h20; d_addr = 32'h24;
    seq = '0; ng = 0;
    for (int c = 0; c < 20 && ng < 6; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        seq = {seq[4:0], if_gnt};
        ng++;
      end
    end
    chk("L contention grants", ng, 6);
    chk("L contention order", seq, 6'b001001);
    tick(); if_req = 0; d_req = 0;
    tick();

    // Address wrap and ignored byte offset
    d_req = 1; d_we = 1; d_addr = 32'h402; d_wdata = 32'h0000A5A5;
    @(negedge clk);
    chk("L wrap wr addr", mem_addr, 0);
    tick(); d_we = 0; d_addr = 32'h403;
    @(negedge clk);
    chk("L wrap rd addr", mem_addr, 0);
    tick(); d_req = 0;
    @(negedge clk);
    chk("L wrap rd data", d_rdata, 32'h0000A5A5);
    tick();

    // Changes after grant do not disturb the read; pulse during busy is dropped
    d_req = 1; d_addr = 32'h10;
    tick(); d_req = 0; d_addr = 32'h20; if_req = 1;
    @(negedge clk);
    chk("L inflight data", d_rdata, 32'h4);
    tick(); if_req = 0;
    @(negedge clk);
    chk("L dropped req", mem_en, 0);
    tick();

    // Reset during the data read cycle aborts the read
    d_req = 1; d_addr = 32'h8;
    @(negedge clk);
    chk("L abort gnt", d_gnt, 1);
    tick(); d_req = 0; reset = 0;
    @(negedge clk);
    chk("L abort valid", d_valid, 0); chk("L abort rdata", d_rdata, 0);
    tick(); reset = 1;
    @(negedge clk);
    chk("L post rst valid", d_valid, 0); chk("L post rst mem_en", mem_en, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iiitb_mem_arbiter.md
IIITB_MEM_ARBITER -- requirements
Module: iiitb_mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, word-address width of the shared memory (256 words).
REQ-002 SHALL have parameter: MAX_D_BURST, 2, maximum consecutive data grants while a fetch is pending.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: if_req  input  1  instruction-fetch read request, held until if_gnt.
REQ-006 SHALL have port: if_addr  input  32  fetch byte address.
REQ-007 SHALL have ports: if_gnt, if_valid  output  1 each  fetch accepted; fetch data valid.
REQ-008 SHALL have port: if_rdata  output  32  fetch read data.
REQ-009 SHALL have ports: d_req, d_we  input  1 each  data request, held until d_gnt; 1 = write.
REQ-010 SHALL have ports: d_addr, d_wdata  input  32 each  data byte address; write data.
REQ-011 SHALL have ports: d_gnt, d_valid  output  1 each  data accepted; read data valid.
REQ-012 SHALL have port: d_rdata  output  32  data read data.
REQ-013 SHALL have ports: mem_en, mem_we  output  1 each  memory access strobe; write enable.
REQ-014 SHALL have ports: mem_addr  output  ADDR_W, and mem_wdata  output  32  word address; write data.
REQ-015 SHALL have port: mem_rdata  input  32  memory read data, valid the cycle after a read strobe.

Function
REQ-016 SHALL implement a 3-state FSM: IDLE, RD_IF, RD_D.
REQ-017 SHALL issue at most one memory access per cycle, and only in IDLE.
REQ-018 In IDLE with any request: SHALL select a winner, assert its gnt combinationally for one cycle, and drive mem_en=1 in the same cycle.
REQ-019 Fetch winner: mem_we=0; next state RD_IF.
REQ-020 Data read winner: mem_we=0; next state RD_D.
REQ-021 Data write winner: mem_we=1 and mem_wdata=d_wdata; next state IDLE, so a write completes in 1 cycle with no d_valid.
REQ-022 RD_IF: if_valid=1 and if_rdata=mem_rdata for exactly one cycle; next state IDLE; no access is issued.
REQ-023 RD_D: d_valid=1 and d_rdata=mem_rdata for exactly one cycle; next state IDLE; no access is issued.
REQ-024 Read latency SHALL be 1 cycle from gnt to valid; back-to-back read throughput is one read per 2 cycles.
REQ-025 mem_addr SHALL be the winner's addr[ADDR_W+1:2]; addr[1:0] and upper bits are ignored, so out-of-range addresses wrap modulo 2^ADDR_W words.
REQ-026 Default priority SHALL be data over fetch.
REQ-027 SHALL keep a counter d_streak, ceil(log2(MAX_D_BURST+1)) bits, that increments on each data grant made while if_req=1.
REQ-028 d_streak SHALL clear on a fetch grant, and in any IDLE cycle with if_req=0.
REQ-029 When d_streak==MAX_D_BURST and if_req=1, fetch SHALL win over data; d_streak SHALL saturate and never wrap.
REQ-030 A request deasserted before its gnt SHALL be dropped silently with no memory access.
REQ-031 Request and address changes after gnt SHALL NOT affect the access in flight.
REQ-032 Outside IDLE, if_gnt, d_gnt and mem_en SHALL be 0.
REQ-033 When not valid, if_rdata/d_rdata SHALL hold their last value; when mem_en=0, mem_we SHALL be 0.

Reset
REQ-034 While reset=0: state=IDLE, d_streak=0, and all outputs 0, including combinational gnt/mem_en, regardless of requests.
REQ-035 Reset asserted during RD_IF/RD_D SHALL abort the read, with no valid pulse after release.
REQ-036 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x8, mem[2]=0x00000002 -> cycle0 if_gnt=1, mem_en=1, mem_addr=2; cycle1 if_valid=1, if_rdata=0x2.
REQ-038 Data write: d_req=1, d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF -> one cycle with d_gnt=1, mem_we=1, mem_addr=2; then a data read of 0x8 returns 0xDEADBEEF with d_valid.
REQ-039 Contention: if_req and d_req held continuously, reads, MAX_D_BURST=2 -> grant order D, D, IF, D, D, IF; no fetch waits more than 4 access slots.
REQ-040 Simultaneous single requests in IDLE -> d_gnt first; if_gnt 2 cycles later; if_valid the cycle after that.
REQ-041 Reset=0 in the RD_D cycle -> d_valid=0, all outputs 0; after release with no request, mem_en stays 0.
REQ-042 Wrap: d_addr=0x400 with ADDR_W=8 -> mem_addr=0; addr bits[1:0]=3 ignored.
